main_mem_arbiter: RTL and testbench
===================================

// Module: main_mem_arbiter
// PURPOSE
//  Shares the single main-memory port between two cache-controller requesters (port 0 = I-cache, port 1 = D-cache).
//  Round-robin grant, one word transfer in flight, held until main memory asserts ready.
//  Sits between the cache FSMs (their main_read/main_write/ready) and the main-memory model.
// PARAMETERS
//  ADDR_W   10  word address width
//  DATA_W   32  data word width
//  TMO_CYC  64  watchdog limit in cycles; used only with MAIN_MEM_ARB_TIMEOUT_EN
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       asynchronous, active-low
//  rq_read      in   2       per-port read request, [p] = port p; held until done[p]
//  rq_write     in   2       per-port write request, held until done[p]
//  rq_addr      in   2*ADDR_W  per-port address, [p*ADDR_W +: ADDR_W]
//  rq_wdata     in   2*DATA_W  per-port write data
//  gnt          out  2       one-hot current owner, 0 when idle
//  done         out  2       1-cycle pulse to owner on transfer completion
//  rdata        out  DATA_W  read data, valid in the done cycle, held until next done
//  err          out  2       1-cycle pulse on watchdog abort (0 without macro)
//  main_read    out  1       read strobe to main memory
//  main_write   out  1       write strobe to main memory
//  main_addr    out  ADDR_W  address to main memory
//  main_wdata   out  DATA_W  write data to main memory
//  main_rdata   in   DATA_W  read data from main memory, valid with ready
//  ready        in   1       main memory completion
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, all outputs 0, rdata=0. Reset mid-transfer aborts silently, no done.
//  Port p is requesting iff rq_read[p]^rq_write[p]; both set = illegal, treated as not requesting.
//  States: IDLE, BUSY, TURN.
//   IDLE: if any port requesting, pick winner (both: port rr_ptr wins), latch owner/op/addr/wdata -> BUSY.
//   BUSY: gnt=onehot(owner); main_read/main_write per latched op; main_addr/wdata from latches.
//         ready=1 -> done[owner]=1 same cycle (combinational), rdata <= main_rdata if read,
//         rr_ptr <= ~owner, -> TURN.
//   TURN: all strobes 0 for 1 cycle so requester drops rq -> IDLE.
//  Latency: request seen cycle N -> strobe cycle N+1 -> done in ready cycle; min back-to-back 3 cycles.
//  Requester changing addr/op while granted has no effect (latched). Dropping rq while BUSY: transfer
//   still completes, done still pulses.
//  ready in IDLE/TURN is ignored. rr_ptr changes only on completion or abort.
//  main_read and main_write are never both 1.
// CONFIGURATION
//  MAIN_MEM_ARB_TIMEOUT_EN defined: 8-bit-or-wider counter clears on BUSY entry, increments each BUSY
//   cycle; reaching TMO_CYC without ready -> err[owner]=1 pulse, no done, rr_ptr <= ~owner, -> TURN.
//  Not defined: no counter; BUSY waits for ready indefinitely; err tied to 0.
// STRUCTURE
//  Package cache_mem_pkg: state enum {IDLE,BUSY,TURN}, op enum {OP_RD,OP_WR}, ADDR_W/DATA_W defaults.
//  Sub-module rr_arb2: combinational 2-way round-robin pick (req[1:0], ptr) -> onehot winner.
// TESTING
//  Single read p0 addr 0x012, ready after 3 cyc, main_rdata=0xDEADBEEF -> done[0] 1 cycle, rdata=0xDEADBEEF.
//  p0 read + p1 write same cycle after reset (rr_ptr=0) -> p0 first, then p1 write, main_wdata=p1 data.
//  Both ports held requesting 4 transfers -> grant order 0,1,0,1; TURN cycle with strobes 0 between each.
//  rq_read[1]&rq_write[1]=1 with p0 idle -> stays IDLE, no strobes, gnt=0.
//  Reset low during BUSY -> outputs 0 next sample, no done; after release new request served normally.
//  TIMEOUT_EN, TMO_CYC=8, ready never -> err[owner] after 8 BUSY cycles, other port granted next.

Source files
------------

// File: rtl/cache_mem_pkg.sv
// Shared types for the cache / main-memory interface.
//   state_e : arbiter FSM states (IDLE, BUSY, TURN)
//   op_e    : latched transfer kind (OP_RD, OP_WR)
//   ADDR_W_DEF / DATA_W_DEF : default word address and data widths
package cache_mem_pkg;
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TURN = 2'd2
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;
endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin pick.
//   req [1:0] : per-port request
//   ptr       : port that wins when both request
//   win [1:0] : one-hot winner, 0 when nobody requests
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] win
);
  always_comb begin
    win = req;
    if (req == 2'b11) win = ptr ? 2'b10 : 2'b01;
  end
endmodule

// File: rtl/main_mem_arbiter.sv
// Shares the single main-memory port between the I-cache (port 0) and the
// D-cache (port 1). Round-robin grant, one word transfer in flight, held
// until main memory asserts ready, then one TURN cycle with all strobes low
// so the finished requester can drop its request.
// Ports:
//   clk, reset            clock (rising), async active-low reset
//   rq_read/rq_write[p]   per-port request, held until done[p]
//   rq_addr/rq_wdata      per-port address / write data, packed by port
//   gnt                   one-hot owner while a transfer is in flight
//   done                  1-cycle completion pulse (same cycle as ready)
//   rdata                 last read word, updated on read completion
//   err                   1-cycle watchdog abort pulse
//   main_*                strobes/address/data to main memory
//   main_rdata, ready     main-memory read data and completion
// Optional build macro MAIN_MEM_ARB_TIMEOUT_EN adds a BUSY watchdog of
// TMO_CYC cycles; without it err is tied to 0 and BUSY waits forever.
module main_mem_arbiter
  import cache_mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TMO_CYC = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          rq_read,
  input  logic [1:0]          rq_write,
  input  logic [2*ADDR_W-1:0] rq_addr,
  input  logic [2*DATA_W-1:0] rq_wdata,
  output logic [1:0]          gnt,
  output logic [1:0]          done,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          err,
  output logic                main_read,
  output logic                main_write,
  output logic [ADDR_W-1:0]   main_addr,
  output logic [DATA_W-1:0]   main_wdata,
  input  logic [DATA_W-1:0]   main_rdata,
  input  logic                ready
);
  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  op_e                 op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rr_ptr_q, rr_ptr_d;

  logic [1:0] req, win, owner_oh;
  logic       busy, tmo;

  // Both strobes set is illegal and must not count as a request.
  assign req = rq_read ^ rq_write;

  rr_arb2 u_rr_arb2 (
    .req (req),
    .ptr (rr_ptr_q),
    .win (win)
  );

  assign busy     = (state_q == BUSY);
  assign owner_oh = owner_q ? 2'b10 : 2'b01;

  assign gnt        = busy ? owner_oh : 2'b00;
  assign main_read  = busy && (op_q == OP_RD);
  assign main_write = busy && (op_q == OP_WR);
  assign main_addr  = busy ? addr_q : '0;
  assign main_wdata = busy ? wdata_q : '0;
  assign done       = (busy && ready) ? owner_oh : 2'b00;
  assign rdata      = rdata_q;

`ifdef MAIN_MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TMO_CYC + 1) > 8) ? $clog2(TMO_CYC + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // cnt_q is 0 in the first BUSY cycle, so TMO_CYC-1 marks the last allowed one.
  assign tmo = busy && !ready && (cnt_q == CNT_W'(TMO_CYC - 1));
  assign err = tmo ? owner_oh : 2'b00;
`else
  assign tmo = 1'b0;
  assign err = 2'b00;
`endif

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rr_ptr_d = rr_ptr_q;
`ifdef MAIN_MEM_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          owner_d = win[1];
          op_d    = rq_write[win[1]] ? OP_WR : OP_RD;
          addr_d  = win[1] ? rq_addr[2*ADDR_W-1:ADDR_W]  : rq_addr[ADDR_W-1:0];
          wdata_d = win[1] ? rq_wdata[2*DATA_W-1:DATA_W] : rq_wdata[DATA_W-1:0];
          state_d = BUSY;
`ifdef MAIN_MEM_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUSY: begin
`ifdef MAIN_MEM_ARB_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        if (ready) begin
          if (op_q == OP_RD) rdata_d = main_rdata;
          rr_ptr_d = ~owner_q;
          state_d  = TURN;
        end else if (tmo) begin
          rr_ptr_d = ~owner_q;
          state_d  = TURN;
        end
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      op_q     <= OP_RD;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rr_ptr_q <= 1'b0;
`ifdef MAIN_MEM_ARB_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rr_ptr_q <= rr_ptr_d;
`ifdef MAIN_MEM_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_main_mem_arbiter.sv
// Self-checking bench for main_mem_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
// Inputs are driven at the falling edge; outputs are sampled 1 ns later.
module tb_main_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
`ifdef MAIN_MEM_ARB_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 64;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [1:0]      rq_read = '0, rq_write = '0;
  logic [2*AW-1:0] rq_addr = '0;
  logic [2*DW-1:0] rq_wdata = '0;
  logic [1:0]      gnt, done, err;
  logic [DW-1:0]   rdata, main_wdata;
  logic [DW-1:0]   main_rdata = '0;
  logic            main_read, main_write;
  logic [AW-1:0]   main_addr;
  logic            ready = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  main_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TMO_CYC(TMO)) dut (
    .clk(clk), .reset(reset),
    .rq_read(rq_read), .rq_write(rq_write), .rq_addr(rq_addr), .rq_wdata(rq_wdata),
    .gnt(gnt), .done(done), .rdata(rdata), .err(err),
    .main_read(main_read), .main_write(main_write), .main_addr(main_addr),
    .main_wdata(main_wdata), .main_rdata(main_rdata), .ready(ready)
  );

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic set_rq(input int p, input bit rd, input bit wr,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    rq_read[p] = rd;
    rq_write[p] = wr;
    rq_addr[p*AW +: AW] = a;
    rq_wdata[p*DW +: DW] = d;
  endtask

  task automatic do_reset();
    nxt();
    reset = 1'b0;
    rq_read = '0; rq_write = '0; ready = 1'b0;
    nxt(); nxt();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    nxt(); #1;
    checks++;
    if ({gnt, done, err, main_read, main_write, main_addr, main_wdata, rdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got gnt=%b done=%b err=%b rd=%b wr=%b addr=%h wd=%h rdata=%h exp all 0",
               gnt, done, err, main_read, main_write, main_addr, main_wdata, rdata);
    end
    nxt();
    reset = 1'b1;
  endtask

  task automatic test_single_read();
    nxt(); set_rq(0, 1, 0, 10'h012, '0); #1;
    checks++;
    if (gnt !== 2'b00) begin errors++; $display("FAIL single_idle_gnt got %b exp 00", gnt); end
    for (int k = 1; k <= 3; k++) begin
      nxt();
      if (k == 3) begin ready = 1'b1; main_rdata = 32'hDEADBEEF; end
      #1;
      checks++;
      if ({gnt, main_read, main_write, main_addr} !== {2'b01, 1'b1, 1'b0, 10'h012}) begin
        errors++;
        $display("FAIL single_strobe cyc %0d got gnt=%b rd=%b wr=%b addr=%h exp 01 1 0 012",
                 k, gnt, main_read, main_write, main_addr);
      end
      checks++;
      if (done !== ((k == 3) ? 2'b01 : 2'b00)) begin
        errors++; $display("FAIL single_done cyc %0d got %b", k, done);
      end
    end
    nxt(); ready = 1'b0; main_rdata = '0; set_rq(0, 0, 0, '0, '0); #1;
    checks++;
    if ({gnt, main_read, main_write, done} !== '0 || rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_turn got gnt=%b rd=%b wr=%b done=%b rdata=%h exp 0s rdata=deadbeef",
               gnt, main_read, main_write, done, rdata);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    nxt();
    set_rq(0, 1, 0, 10'h0A0, '0);
    set_rq(1, 0, 1, 10'h1B1, 32'hA5A5_0F0F);
    #1;
    nxt(); ready = 1'b1; main_rdata = 32'h1111_2222; #1;
    checks++;
    if ({gnt, main_read, main_write, main_addr, done} !== {2'b01, 1'b1, 1'b0, 10'h0A0, 2'b01}) begin
      errors++;
      $display("FAIL simul_first got gnt=%b rd=%b wr=%b addr=%h done=%b exp 01 1 0 0a0 01",
               gnt, main_read, main_write, main_addr, done);
    end
    nxt(); ready = 1'b0; set_rq(0, 0, 0, '0, '0); #1;
    checks++;
    if ({gnt, main_read, main_write} !== '0) begin
      errors++; $display("FAIL simul_turn got gnt=%b rd=%b wr=%b exp 0", gnt, main_read, main_write);
    end
    nxt(); #1;
    nxt(); ready = 1'b1; main_rdata = 32'h3333_4444; #1;
    checks++;
    if ({gnt, main_read, main_write, main_addr, main_wdata, done} !==
        {2'b10, 1'b0, 1'b1, 10'h1B1, 32'hA5A5_0F0F, 2'b10}) begin
      errors++;
      $display("FAIL simul_second got gnt=%b rd=%b wr=%b addr=%h wd=%h done=%b exp 10 0 1 1b1 a5a50f0f 10",
               gnt, main_read, main_write, main_addr, main_wdata, done);
    end
    nxt(); ready = 1'b0; set_rq(1, 0, 0, '0, '0); #1;
    checks++;
    if (rdata !== 32'h1111_2222) begin
      errors++; $display("FAIL simul_rdata_hold got %h exp 11112222", rdata);
    end
  endtask

  task automatic test_back_to_back();
    int order[$];
    int last_c;
    bit after_done;
    last_c = 0;
    after_done = 1'b0;
    do_reset();
    nxt();
    set_rq(0, 1, 0, 10'h100, '0);
    set_rq(1, 0, 1, 10'h200, 32'h5555_0001);
    for (int c = 0; c < 40 && order.size() < 4; c++) begin
      nxt(); ready = main_read | main_write; #1;
      if (after_done) begin
        checks++;
        if ({gnt, main_read, main_write} !== '0) begin
          errors++; $display("FAIL b2b_turn got gnt=%b rd=%b wr=%b exp 0", gnt, main_read, main_write);
        end
      end
      after_done = (done != 2'b00);
      if (done != 2'b00) begin
        order.push_back(done[1] ? 1 : 0);
        if (order.size() > 1) begin
          checks++;
          if (c - last_c != 3) begin
            errors++; $display("FAIL b2b_spacing got %0d exp 3", c - last_c);
          end
        end
        last_c = c;
      end
    end
    checks++;
    if (order.size() != 4) begin
      errors++; $display("FAIL b2b_count got %0d exp 4", order.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (order[i] != i % 2) begin
          errors++; $display("FAIL b2b_order idx %0d got %0d exp %0d", i, order[i], i % 2);
        end
      end
    end
    nxt(); ready = 1'b0; rq_read = '0; rq_write = '0;
    nxt(); nxt(); nxt();
  endtask

  task automatic test_illegal();
    nxt(); set_rq(1, 1, 1, 10'h2AA, 32'h7);
    for (int k = 0; k < 5; k++) begin
      nxt(); ready = (k == 2); #1;
      checks++;
      if ({gnt, main_read, main_write, done} !== '0) begin
        errors++;
        $display("FAIL illegal_idle cyc %0d got gnt=%b rd=%b wr=%b done=%b exp 0",
                 k, gnt, main_read, main_write, done);
      end
    end
    nxt(); ready = 1'b0; set_rq(1, 0, 0, '0, '0);
  endtask

  task automatic test_reset_mid();
    nxt(); set_rq(0, 0, 1, 10'h3FF, 32'hCAFE_F00D);
    nxt(); #1;
    checks++;
    if ({gnt, main_write} !== {2'b01, 1'b1}) begin
      errors++; $display("FAIL rstmid_busy got gnt=%b wr=%b exp 01 1", gnt, main_write);
    end
    nxt(); ready = 1'b1; reset = 1'b0; #1;
    checks++;
    if ({gnt, done, err, main_read, main_write, main_addr, main_wdata} !== '0) begin
      errors++;
      $display("FAIL rstmid_abort got gnt=%b done=%b err=%b rd=%b wr=%b addr=%h wd=%h exp 0",
               gnt, done, err, main_read, main_write, main_addr, main_wdata);
    end
    nxt(); ready = 1'b0; set_rq(0, 0, 0, '0, '0);
    nxt(); reset = 1'b1;
    nxt(); set_rq(1, 1, 0, 10'h055, '0); #1;
    nxt(); ready = 1'b1; main_rdata = 32'h1234_5678; #1;
    checks++;
    if ({gnt, main_read, main_addr, done} !== {2'b10, 1'b1, 10'h055, 2'b10}) begin
      errors++;
      $display("FAIL rstmid_after got gnt=%b rd=%b addr=%h done=%b exp 10 1 055 10",
               gnt, main_read, main_addr, done);
    end
    nxt(); ready = 1'b0; set_rq(1, 0, 0, '0, '0); #1;
    checks++;
    if (rdata !== 32'h1234_5678) begin
      errors++; $display("FAIL rstmid_rdata got %h exp 12345678", rdata);
    end
  endtask

`ifdef MAIN_MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    nxt(); set_rq(0, 1, 0, 10'h001, '0); set_rq(1, 1, 0, 10'h002, '0);
    for (int k = 1; k <= TMO; k++) begin
      nxt(); #1;
      checks++;
      if ({gnt, done, err} !== {2'b01, 2'b00, (k == TMO) ? 2'b01 : 2'b00}) begin
        errors++;
        $display("FAIL tmo_busy cyc %0d got gnt=%b done=%b err=%b", k, gnt, done, err);
      end
    end
    nxt(); #1;
    checks++;
    if ({gnt, err} !== '0) begin errors++; $display("FAIL tmo_turn got gnt=%b err=%b exp 0", gnt, err); end
    nxt(); #1;
    nxt(); ready = 1'b1; #1;
    checks++;
    if ({gnt, done} !== {2'b10, 2'b10}) begin
      errors++; $display("FAIL tmo_next got gnt=%b done=%b exp 10 10", gnt, done);
    end
    nxt(); ready = 1'b0; rq_read = '0; rq_write = '0;
    nxt(); nxt();
  endtask
`else
  task automatic test_no_timeout();
    bit bad;
    bad = 1'b0;
    do_reset();
    nxt(); set_rq(0, 1, 0, 10'h001, '0);
    for (int k = 0; k < TMO + 16; k++) begin
      nxt(); #1;
      if (err !== 2'b00 || done !== 2'b00) bad = 1'b1;
    end
    checks++;
    if (bad || gnt !== 2'b01) begin
      errors++; $display("FAIL no_tmo_wait got gnt=%b bad=%0d exp gnt=01 bad=0", gnt, bad);
    end
    nxt(); ready = 1'b1; #1;
    nxt(); ready = 1'b0; set_rq(0, 0, 0, '0, '0);
    nxt(); nxt();
  endtask
`endif

  // Reference model: tracks whole transfers (who owns the port, what was
  // latched, which port is favoured next) and derives the port activity.
  task automatic test_random();
    int m_busy, m_ptr, m_cnt, win;
    bit m_cool, m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd, m_rd;
    bit act[2];
    int ill[2];
    logic [1:0] prev_done, prev_err, e_gnt, e_done, e_err;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    bit rqp[2];
    bit wr;
    do_reset();
    m_busy = -1; m_ptr = 0; m_cnt = 0; m_cool = 1'b0; m_wr = 1'b0;
    m_addr = '0; m_wd = '0; m_rd = '0;
    act = '{0, 0}; ill = '{0, 0};
    prev_done = '0; prev_err = '0;
    for (int c = 0; c < 600; c++) begin
      nxt();
      for (int p = 0; p < 2; p++) begin
        if (act[p]) begin
          if (prev_done[p] || prev_err[p]) begin
            act[p] = 1'b0; rq_read[p] = 1'b0; rq_write[p] = 1'b0;
          end else if ($urandom_range(0, 3) == 0) begin
            rq_addr[p*AW +: AW] = AW'($urandom);
          end
        end else if (ill[p] > 0) begin
          ill[p]--;
          if (ill[p] == 0) begin rq_read[p] = 1'b0; rq_write[p] = 1'b0; end
        end else begin
          case ($urandom_range(0, 5))
            0, 1: begin
              act[p] = 1'b1;
              wr = 1'($urandom_range(0, 1));
              rq_read[p] = !wr; rq_write[p] = wr;
              rq_addr[p*AW +: AW] = AW'($urandom);
              rq_wdata[p*DW +: DW] = $urandom;
            end
            2: begin ill[p] = $urandom_range(1, 3); rq_read[p] = 1'b1; rq_write[p] = 1'b1; end
            default: ;
          endcase
        end
      end
      if (main_read | main_write) ready = ($urandom_range(0, 2) == 0);
      else ready = ($urandom_range(0, 3) == 0);
      main_rdata = $urandom;
      #1;
      e_gnt  = (m_busy >= 0) ? 2'(1 << m_busy) : 2'b00;
      e_addr = (m_busy >= 0) ? m_addr : '0;
      e_wd   = (m_busy >= 0) ? m_wd : '0;
      e_done = (m_busy >= 0 && ready) ? e_gnt : 2'b00;
`ifdef MAIN_MEM_ARB_TIMEOUT_EN
      e_err  = (m_busy >= 0 && !ready && m_cnt == TMO - 1) ? e_gnt : 2'b00;
`else
      e_err  = 2'b00;
`endif
      checks++;
      if ({gnt, main_read, main_write, main_addr, main_wdata} !==
          {e_gnt, m_busy >= 0 && !m_wr, m_busy >= 0 && m_wr, e_addr, e_wd}) begin
        errors++;
        $display("FAIL rand_port cyc %0d got gnt=%b rd=%b wr=%b addr=%h wd=%h exp gnt=%b rd=%b wr=%b addr=%h wd=%h",
                 c, gnt, main_read, main_write, main_addr, main_wdata,
                 e_gnt, m_busy >= 0 && !m_wr, m_busy >= 0 && m_wr, e_addr, e_wd);
      end
      checks++;
      if ({done, err, rdata} !== {e_done, e_err, m_rd}) begin
        errors++;
        $display("FAIL rand_resp cyc %0d got done=%b err=%b rdata=%h exp done=%b err=%b rdata=%h",
                 c, done, err, rdata, e_done, e_err, m_rd);
      end
      prev_done = done;
      prev_err  = err;
      if (m_busy >= 0) begin
        if (ready) begin
          if (!m_wr) m_rd = main_rdata;
          m_ptr = 1 - m_busy; m_busy = -1; m_cool = 1'b1;
        end else if (e_err != 2'b00) begin
          m_ptr = 1 - m_busy; m_busy = -1; m_cool = 1'b1;
        end else begin
          m_cnt++;
        end
      end else if (m_cool) begin
        m_cool = 1'b0;
      end else begin
        for (int p = 0; p < 2; p++) rqp[p] = rq_read[p] ^ rq_write[p];
        if (rqp[0] || rqp[1]) begin
          win = (rqp[0] && rqp[1]) ? m_ptr : (rqp[1] ? 1 : 0);
          m_busy = win;
          m_wr   = rq_write[win];
          m_addr = rq_addr[win*AW +: AW];
          m_wd   = rq_wdata[win*DW +: DW];
          m_cnt  = 0;
        end
      end
    end
    nxt(); rq_read = '0; rq_write = '0; ready = 1'b1;
    nxt(); nxt(); nxt(); ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
`ifdef MAIN_MEM_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
